// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding read per fetch, with misalignment,
// bus-error and timeout faults reported alongside the held instruction.
module ifu_fetch #(
    parameter int unsigned          CPU_Width    = 32,
    parameter logic [CPU_Width-1:0] RESET_VECTOR = CPU_Width'(32'h8000_0000),
    parameter int unsigned          TIMEOUT      = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CPU_Width-1:0] i_ifu_npc,
    input  logic                 i_ifu_fetch,
    output logic [CPU_Width-1:0] o_ifu_araddr,
    output logic                 o_ifu_arvalid,
    input  logic                 i_ifu_arready,
    input  logic [31:0]          i_ifu_rdata,
    input  logic [1:0]           i_ifu_rresp,
    input  logic                 i_ifu_rvalid,
    output logic                 o_ifu_rready,
    output logic [CPU_Width-1:0] o_ifu_pc,
    output logic [31:0]          o_ifu_inst,
    output logic [1:0]           o_ifu_fault,
    output logic                 o_ifu_valid,
    input  logic                 i_ifu_ready
);

    localparam int unsigned CNT_W = 10;

    localparam logic [1:0] FAULT_NONE = 2'd0;
    localparam logic [1:0] FAULT_MIS  = 2'd1;
    localparam logic [1:0] FAULT_BUS  = 2'd2;
    localparam logic [1:0] FAULT_TMO  = 2'd3;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} state_t;

    state_t               state;
    logic                 pending;
    logic [CPU_Width-1:0] pc_q;
    logic [CNT_W-1:0]     wait_cnt;
    logic                 timeout_hit_c;

    // Last counted bus cycle of this fetch; a handshake in it still wins.
    assign timeout_hit_c = (wait_cnt >= CNT_W'(TIMEOUT - 1));

    assign o_ifu_pc = pc_q;

    // Fetch FSM with all bus and IDU outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            pending       <= 1'b1;
            pc_q          <= RESET_VECTOR;
            wait_cnt      <= '0;
            o_ifu_araddr  <= '0;
            o_ifu_arvalid <= 1'b0;
            o_ifu_rready  <= 1'b0;
            o_ifu_inst    <= '0;
            o_ifu_fault   <= FAULT_NONE;
            o_ifu_valid   <= 1'b0;
        end else begin
            if (i_ifu_fetch) begin
                pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (pending || i_ifu_fetch) begin
                        pending  <= 1'b0;
                        pc_q     <= i_ifu_npc;
                        wait_cnt <= '0;
                        if (i_ifu_npc[1:0] != 2'b00) begin
                            state       <= HOLD;
                            o_ifu_inst  <= '0;
                            o_ifu_fault <= FAULT_MIS;
                            o_ifu_valid <= 1'b1;
                        end else begin
                            state         <= ADDR;
                            o_ifu_araddr  <= i_ifu_npc;
                            o_ifu_arvalid <= 1'b1;
                        end
                    end
                end
                ADDR: begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                    if (i_ifu_arready) begin
                        state         <= DATA;
                        o_ifu_arvalid <= 1'b0;
                        o_ifu_araddr  <= '0;
                        o_ifu_rready  <= 1'b1;
                    end else if (timeout_hit_c) begin
                        state         <= HOLD;
                        o_ifu_arvalid <= 1'b0;
                        o_ifu_araddr  <= '0;
                        o_ifu_inst    <= '0;
                        o_ifu_fault   <= FAULT_TMO;
                        o_ifu_valid   <= 1'b1;
                    end
                end
                DATA: begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                    if (i_ifu_rvalid) begin
                        state        <= HOLD;
                        o_ifu_rready <= 1'b0;
                        o_ifu_inst   <= i_ifu_rdata;
                        o_ifu_fault  <= (i_ifu_rresp != 2'b00) ? FAULT_BUS : FAULT_NONE;
                        o_ifu_valid  <= 1'b1;
                    end else if (timeout_hit_c) begin
                        state        <= HOLD;
                        o_ifu_rready <= 1'b0;
                        o_ifu_inst   <= '0;
                        o_ifu_fault  <= FAULT_TMO;
                        o_ifu_valid  <= 1'b1;
                    end
                end
                HOLD: begin
                    if (i_ifu_ready) begin
                        state       <= IDLE;
                        o_ifu_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch (TIMEOUT reduced to 8 to exercise the timeout).
module tb_ifu_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] npc;
    logic        fetch;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [1:0]  fault;
    logic        valid;
    logic        ready;

    int checks;
    int failures;

    ifu_fetch #(
        .CPU_Width   (32),
        .RESET_VECTOR(32'h8000_0000),
        .TIMEOUT     (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_ifu_npc    (npc),
        .i_ifu_fetch  (fetch),
        .o_ifu_araddr (araddr),
        .o_ifu_arvalid(arvalid),
        .i_ifu_arready(arready),
        .i_ifu_rdata  (rdata),
        .i_ifu_rresp  (rresp),
        .i_ifu_rvalid (rvalid),
        .o_ifu_rready (rready),
        .o_ifu_pc     (pc),
        .o_ifu_inst   (inst),
        .o_ifu_fault  (fault),
        .o_ifu_valid  (valid),
        .i_ifu_ready  (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        arready = 1'b0;
        rvalid  = 1'b0;
        rdata   = 32'h0;
        rresp   = 2'b00;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst   = 1'b0;
        npc   = 32'h8000_0000;
        fetch = 1'b0;
        ready = 1'b0;
        bus_idle();

        // Reset values
        tick();
        check("rst_arvalid", 32'(arvalid), 32'd0);
        check("rst_rready",  32'(rready),  32'd0);
        check("rst_valid",   32'(valid),   32'd0);
        check("rst_araddr",  araddr,       32'h0);
        check("rst_pc",      pc,           32'h8000_0000);
        check("rst_inst",    inst,         32'h0);
        check("rst_fault",   32'(fault),   32'd0);

        // Zero-wait bus first fetch from reset
        rst     = 1'b1;
        arready = 1'b1;
        rvalid  = 1'b1;
        rdata   = 32'h0000_0413;
        tick();
        check("zw_c1_arvalid", 32'(arvalid), 32'd1);
        check("zw_c1_araddr",  araddr,       32'h8000_0000);
        check("zw_c1_valid",   32'(valid),   32'd0);
        tick();
        check("zw_c2_rready",  32'(rready),  32'd1);
        check("zw_c2_arvalid", 32'(arvalid), 32'd0);
        check("zw_c2_valid",   32'(valid),   32'd0);
        tick();
        check("zw_c3_valid", 32'(valid), 32'd1);
        check("zw_c3_pc",    pc,          32'h8000_0000);
        check("zw_c3_inst",  inst,        32'h0000_0413);
        check("zw_c3_fault", 32'(fault),  32'd0);
        bus_idle();
        ready = 1'b1;
        tick();
        check("zw_done_valid", 32'(valid), 32'd0);
        ready = 1'b0;

        // arready delayed four cycles
        npc   = 32'h8000_0100;
        fetch = 1'b1;
        tick();
        fetch = 1'b0;
        check("dly_arvalid0", 32'(arvalid), 32'd1);
        check("dly_araddr0",  araddr,       32'h8000_0100);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("dly_arvalid", 32'(arvalid), 32'd1);
            check("dly_araddr",  araddr,       32'h8000_0100);
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        check("dly_rready", 32'(rready), 32'd1);
        rvalid = 1'b1;
        rdata  = 32'h1234_5678;
        tick();
        bus_idle();
        check("dly_valid", 32'(valid), 32'd1);
        check("dly_inst",  inst,        32'h1234_5678);
        check("dly_pc",    pc,          32'h8000_0100);
        check("dly_fault", 32'(fault),  32'd0);
        ready = 1'b1;
        tick();
        ready = 1'b0;

        // Misaligned fetch
        npc   = 32'h8000_0002;
        fetch = 1'b1;
        tick();
        fetch = 1'b0;
        check("mis_arvalid", 32'(arvalid), 32'd0);
        check("mis_valid",   32'(valid),   32'd1);
        check("mis_fault",   32'(fault),   32'd1);
        check("mis_pc",      pc,           32'h8000_0002);
        ready = 1'b1;
        tick();
        ready = 1'b0;

        // Bus error response
        npc     = 32'h8000_0200;
        fetch   = 1'b1;
        arready = 1'b1;
        rvalid  = 1'b1;
        rdata   = 32'hDEAD_BEEF;
        rresp   = 2'b10;
        tick();
        fetch = 1'b0;
        tick();
        tick();
        bus_idle();
        check("berr_valid", 32'(valid), 32'd1);
        check("berr_fault", 32'(fault), 32'd2);
        check("berr_inst",  inst,        32'hDEAD_BEEF);
        ready = 1'b1;
        tick();
        ready = 1'b0;

        // Silent bus times out after 8 cycles; late response ignored
        npc   = 32'h8000_0300;
        fetch = 1'b1;
        tick();
        fetch = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("tmo_pre_arvalid", 32'(arvalid), 32'd1);
        check("tmo_pre_valid",   32'(valid),   32'd0);
        tick();
        check("tmo_valid",   32'(valid),   32'd1);
        check("tmo_fault",   32'(fault),   32'd3);
        check("tmo_inst",    inst,         32'h0);
        check("tmo_rready",  32'(rready),  32'd0);
        check("tmo_arvalid", 32'(arvalid), 32'd0);
        rvalid = 1'b1;
        rdata  = 32'hFFFF_FFFF;
        tick();
        bus_idle();
        check("late_inst",  inst,        32'h0);
        check("late_fault", 32'(fault),  32'd3);
        ready = 1'b1;
        tick();
        ready = 1'b0;

        // arready in the last counted cycle beats the timeout
        npc   = 32'h8000_0380;
        fetch = 1'b1;
        tick();
        fetch = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        arready = 1'b1;
        tick();
        arready = 1'b0;
        check("edge_rready", 32'(rready), 32'd1);
        check("edge_valid",  32'(valid),  32'd0);
        rvalid = 1'b1;
        rdata  = 32'h0000_0013;
        tick();
        bus_idle();
        check("edge_hold_valid", 32'(valid), 32'd1);
        ready = 1'b1;
        tick();
        ready = 1'b0;

        // Fetch pulsed during DATA queues a second fetch
        npc     = 32'h8000_0400;
        fetch   = 1'b1;
        arready = 1'b1;
        tick();
        fetch = 1'b0;
        tick();
        arready = 1'b0;
        npc     = 32'h8000_0500;
        fetch   = 1'b1;
        tick();
        fetch  = 1'b0;
        rvalid = 1'b1;
        rdata  = 32'h1111_1111;
        tick();
        bus_idle();
        check("pend_inst", inst, 32'h1111_1111);
        check("pend_pc",   pc,   32'h8000_0400);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("pend_idle_valid", 32'(valid), 32'd0);
        tick();
        check("pend_arvalid", 32'(arvalid), 32'd1);
        check("pend_araddr",  araddr,       32'h8000_0500);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid  = 1'b1;
        rdata   = 32'h2222_2222;
        tick();
        bus_idle();
        check("pend2_pc",   pc,   32'h8000_0500);
        check("pend2_inst", inst, 32'h2222_2222);

        // ready and fetch together in HOLD: exactly one further fetch
        npc   = 32'h8000_0600;
        ready = 1'b1;
        fetch = 1'b1;
        tick();
        ready = 1'b0;
        fetch = 1'b0;
        check("rf_idle_valid",   32'(valid),   32'd0);
        check("rf_idle_arvalid", 32'(arvalid), 32'd0);
        tick();
        check("rf_arvalid", 32'(arvalid), 32'd1);
        check("rf_araddr",  araddr,       32'h8000_0600);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid  = 1'b1;
        rdata   = 32'h3333_3333;
        tick();
        bus_idle();
        check("rf_valid", 32'(valid), 32'd1);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        tick();
        tick();
        check("rf_single_arvalid", 32'(arvalid), 32'd0);
        check("rf_single_valid",   32'(valid),   32'd0);

        // Reset in the middle of DATA, then refetch from the reset vector
        npc     = 32'h8000_0000;
        fetch   = 1'b1;
        arready = 1'b1;
        tick();
        fetch = 1'b0;
        tick();
        arready = 1'b0;
        check("mr_rready_pre", 32'(rready), 32'd1);
        rst = 1'b0;
        #1;
        check("mr_rready",  32'(rready),  32'd0);
        check("mr_arvalid", 32'(arvalid), 32'd0);
        check("mr_valid",   32'(valid),   32'd0);
        check("mr_pc",      pc,           32'h8000_0000);
        tick();
        rst = 1'b1;
        tick();
        check("mr_re_arvalid", 32'(arvalid), 32'd1);
        check("mr_re_araddr",  araddr,       32'h8000_0000);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid  = 1'b1;
        rdata   = 32'h0000_0413;
        tick();
        bus_idle();
        check("mr_re_valid", 32'(valid), 32'd1);
        check("mr_re_inst",  inst,        32'h0000_0413);
        check("mr_re_fault", 32'(fault),  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter CPU_Width, default 32, SHALL set the width of the address, PC and instruction paths.
REQ-002 Parameter RESET_VECTOR, default 32'h8000_0000, SHALL be the PC value loaded at reset.
REQ-003 Parameter TIMEOUT, default 255, SHALL be the maximum bus wait in cycles per fetch, range 1..1023.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port i_ifu_npc, input, CPU_Width bits: next PC from the branch unit.
REQ-007 Port i_ifu_fetch, input, 1 bit: one-cycle request from the WBU to fetch at i_ifu_npc.
REQ-008 Port o_ifu_araddr, output, CPU_Width bits: read address.
REQ-009 Port o_ifu_arvalid, output, 1 bit: read-address valid.
REQ-010 Port i_ifu_arready, input, 1 bit: read-address ready.
REQ-011 Port i_ifu_rdata, input, 32 bits: read data.
REQ-012 Port i_ifu_rresp, input, 2 bits: read response; 2'b00 means OKAY.
REQ-013 Port i_ifu_rvalid, input, 1 bit: read-data valid.
REQ-014 Port o_ifu_rready, output, 1 bit: read-data ready.
REQ-015 Port o_ifu_pc, output, CPU_Width bits: PC of the held instruction.
REQ-016 Port o_ifu_inst, output, 32 bits: the held instruction.
REQ-017 Port o_ifu_fault, output, 2 bits: fault code; 0 none, 1 misaligned, 2 bus error, 3 timeout.
REQ-018 Port o_ifu_valid, output, 1 bit: instruction valid towards the IDU.
REQ-019 Port i_ifu_ready, input, 1 bit: IDU ready.

Function
REQ-020 The FSM SHALL have four states: IDLE, ADDR, DATA and HOLD.
REQ-021 A one-deep pending flag SHALL set whenever i_ifu_fetch=1, in any state.
REQ-022 IDLE SHALL start a fetch when pending=1 or i_ifu_fetch=1:
- the pending flag clears;
- pc_q latches i_ifu_npc;
- the wait counter clears.
REQ-023 When a fetch starts and i_ifu_npc[1:0]!=0, the FSM SHALL go to HOLD with fault=1 and issue no bus request; otherwise it SHALL go to ADDR.
REQ-024 ADDR SHALL drive o_ifu_arvalid=1 and o_ifu_araddr=pc_q, held stable until i_ifu_arready=1, then go to DATA.
REQ-025 DATA SHALL drive o_ifu_rready=1; on i_ifu_rvalid=1 it SHALL:
- latch i_ifu_rdata into the instruction register;
- set fault=2 when i_ifu_rresp!=0, else fault=0;
- go to HOLD.
REQ-026 The wait counter SHALL increment each cycle in ADDR or DATA; reaching TIMEOUT SHALL force HOLD with fault=3, the instruction register set to 0, and arvalid and rready deasserted.
REQ-027 A response arriving after a timeout SHALL be ignored.
REQ-028 HOLD SHALL drive o_ifu_valid=1 with o_ifu_pc, o_ifu_inst and o_ifu_fault stable; on i_ifu_ready=1 it SHALL go to IDLE.
REQ-029 o_ifu_valid SHALL be 0 in IDLE, ADDR and DATA.
REQ-030 Latency with a zero-wait bus SHALL be: fetch start to ADDR 1 cycle; arready to DATA 1 cycle; rvalid to o_ifu_valid 1 cycle.
REQ-031 When i_ifu_fetch=1 and i_ifu_ready=1 fall in the same HOLD cycle, the FSM SHALL move to IDLE with pending set, and the fetch SHALL start in the next cycle.
REQ-032 When i_ifu_arready=1 arrives in the last counted cycle, the handshake SHALL win over the timeout.

Reset
REQ-033 While rst=0 the block SHALL force:
- the FSM to IDLE;
- pending=1;
- pc_q=RESET_VECTOR;
- the wait counter to 0;
- every output to 0, except o_ifu_pc=RESET_VECTOR.
REQ-034 Asserting rst in the middle of a fetch SHALL abandon the transaction at once; after rst rises, a fetch SHALL start from i_ifu_npc in the first cycle.

Verification
REQ-035 Reset, then a zero-wait bus, i_ifu_npc=0x8000_0000, rdata=0x00000413 -> o_ifu_valid=1 on cycle 3, pc=0x8000_0000, inst=0x00000413, fault=0.
REQ-036 arready delayed 4 cycles -> araddr and arvalid stay stable for all 5 cycles; then a normal completion.
REQ-037 i_ifu_npc=0x8000_0002 with i_ifu_fetch=1 -> no arvalid, HOLD with fault=1, pc=0x8000_0002.
REQ-038 rresp=2'b10 -> fault=2 with the data captured; TIMEOUT=8 and a silent bus -> fault=3, inst=0, rready=0.
REQ-039 i_ifu_fetch pulsed during DATA -> a second fetch starts the cycle after the HOLD handshake; ready and fetch in the same cycle -> one fetch only.
REQ-040 rst pulled low while in DATA -> arvalid, rready and valid go to 0 immediately; after release, a refetch at RESET_VECTOR.
